mem_bus_arbiter: RTL

//  Two-master arbiter sharing one single-port, 1-cycle-read-latency memory port.

---
 rtl/mem_bus_arbiter_if.sv | 16 +
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle for one side of the memory arbiter: rstrb/wmask requests,
// read data and busy flags. The requester drives through master, the responder through slave.
interface mem_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic [3:0]            wmask;
   logic                  rstrb;
   logic [31:0]           rdata;
   logic                  rbusy;
   logic                  wbusy;

   modport master (output addr, wdata, wmask, rstrb, input  rdata, rbusy, wbusy);
   modport slave  (input  addr, wdata, wmask, rstrb, output rdata, rbusy, wbusy);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port memory with 1-cycle read latency.
// Zero-cycle grant, one pending slot per master, round-robin or fixed priority.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit RR_ENABLE  = 1'b1
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.slave  m0,
   mem_bus_arbiter_if.slave  m1,
   mem_bus_arbiter_if.master s
);
   logic [ADDR_WIDTH-1:0] req_addr  [2];
   logic [31:0]           req_wdata [2];
   logic [3:0]            req_wmask [2];
   logic [1:0]            req_rstrb;
   logic [1:0]            req_live;

   logic [1:0]            pend_vld;
   logic [1:0]            pend_rd;
   logic [ADDR_WIDTH-1:0] pend_addr  [2];
   logic [31:0]           pend_wdata [2];
   logic [3:0]            pend_wmask [2];

   logic [1:0]            cand_vld;
   logic [1:0]            cand_rd;
   logic [ADDR_WIDTH-1:0] cand_addr  [2];
   logic [31:0]           cand_wdata [2];
   logic [3:0]            cand_wmask [2];

   logic                  grant;
   logic                  win;
   logic [1:0]            grant_vec;
   logic                  last_grant;
   logic                  ret_vld;
   logic                  ret_owner;
   logic [31:0]           rdata_q [2];
   logic                  unused_busy;

   assign req_addr[0]  = m0.addr;
   assign req_addr[1]  = m1.addr;
   assign req_wdata[0] = m0.wdata;
   assign req_wdata[1] = m1.wdata;
   assign req_wmask[0] = m0.wmask;
   assign req_wmask[1] = m1.wmask;
   assign req_rstrb    = {m1.rstrb, m0.rstrb};
   assign req_live[0]  = req_rstrb[0] | (|req_wmask[0]);
   assign req_live[1]  = req_rstrb[1] | (|req_wmask[1]);

   // A held slot shadows any new request from the same master; wmask wins over rstrb.
   always_comb begin
      for (int x = 0; x < 2; x++) begin
         if (pend_vld[x]) begin
            cand_vld[x]   = ~reset;
            cand_rd[x]    = pend_rd[x];
            cand_addr[x]  = pend_addr[x];
            cand_wdata[x] = pend_wdata[x];
            cand_wmask[x] = pend_wmask[x];
         end else begin
            cand_vld[x]   = ~reset & req_live[x];
            cand_rd[x]    = ~|req_wmask[x];
            cand_addr[x]  = req_addr[x];
            cand_wdata[x] = req_wdata[x];
            cand_wmask[x] = req_wmask[x];
         end
      end
   end

   assign grant     = |cand_vld;
   assign win       = (&cand_vld) ? (RR_ENABLE ? ~last_grant : 1'b0) : ~cand_vld[0];
   assign grant_vec = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

   assign s.addr  = grant ? cand_addr[win]  : req_addr[0];
   assign s.wdata = grant ? cand_wdata[win] : req_wdata[0];
   assign s.rstrb = grant & cand_rd[win];
   assign s.wmask = (grant & ~cand_rd[win]) ? cand_wmask[win] : 4'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_vld   <= '0;
         pend_rd    <= '0;
         last_grant <= 1'b1;
         ret_vld    <= 1'b0;
         ret_owner  <= 1'b0;
         for (int x = 0; x < 2; x++) begin
            pend_addr[x]  <= '0;
            pend_wdata[x] <= '0;
            pend_wmask[x] <= '0;
            rdata_q[x]    <= '0;
         end
      end else begin
         for (int x = 0; x < 2; x++) begin
            if (grant_vec[x]) begin
               pend_vld[x] <= 1'b0;
            end else if (!pend_vld[x] && req_live[x]) begin
               pend_vld[x]   <= 1'b1;
               pend_rd[x]    <= ~|req_wmask[x];
               pend_addr[x]  <= req_addr[x];
               pend_wdata[x] <= req_wdata[x];
               pend_wmask[x] <= req_wmask[x];
            end
         end
         if (grant) last_grant <= win;
         ret_vld   <= grant & cand_rd[win];
         ret_owner <= win;
         if (ret_vld) rdata_q[ret_owner] <= s.rdata;
      end
   end

   assign m0.rdata = (ret_vld && !ret_owner) ? s.rdata : rdata_q[0];
   assign m1.rdata = (ret_vld &&  ret_owner) ? s.rdata : rdata_q[1];
   assign m0.rbusy = ~reset & pend_vld[0] &  pend_rd[0];
   assign m0.wbusy = ~reset & pend_vld[0] & ~pend_rd[0];
   assign m1.rbusy = ~reset & pend_vld[1] &  pend_rd[1];
   assign m1.wbusy = ~reset & pend_vld[1] & ~pend_rd[1];

   // The memory side never reports busy; those inputs exist only because the bundle is shared.
   assign unused_busy = s.rbusy | s.wbusy;
endmodule
